// File: rtl/stash_scan_slotter_if.sv
// stash_scan_slotter_if: scan-entry and scan-table handshake bundle for stash_scan_slotter
interface stash_scan_slotter_if #(
  parameter int ORAML = 3,
  parameter int ORAMZ = 4,
  parameter int StashEAWidth = 6
);
  localparam int ScanTableAWidth = $clog2((ORAML + 1) * ORAMZ);
  logic PerAccessReset;
  logic ResetDone;
  logic [ORAML-1:0] CurrentLeaf;
  logic [ORAML-1:0] InLeaf;
  logic [StashEAWidth-1:0] InSAddr;
  logic InValid;
  logic [StashEAWidth-1:0] OutSAddr;
  logic OutAccepted;
  logic OutValid;
  logic [ScanTableAWidth-1:0] InSTAddr;
  logic InSTValid;
  logic InSTReset;
  logic [StashEAWidth-1:0] OutSTAddr;
  logic OutSTValid;
  modport master (
    output PerAccessReset, CurrentLeaf, InLeaf, InSAddr, InValid, InSTAddr, InSTValid, InSTReset,
    input ResetDone, OutSAddr, OutAccepted, OutValid, OutSTAddr, OutSTValid
  );
  modport slave (
    input PerAccessReset, CurrentLeaf, InLeaf, InSAddr, InValid, InSTAddr, InSTValid, InSTReset,
    output ResetDone, OutSAddr, OutAccepted, OutValid, OutSTAddr, OutSTValid
  );
endinterface

// File: rtl/stash_scan_slotter.sv
// stash_scan_slotter: places scanned stash entries into the deepest free common bucket of the access path.
// Optional SCAN_TABLE_CHECK_EN adds a simulation-only collision check on the scan-table port.
module stash_scan_slotter #(
  parameter int ORAML = 3,
  parameter int ORAMZ = 4,
  parameter int StashEAWidth = 6
) (
  input logic Clock,
  input logic Reset,
  stash_scan_slotter_if.slave bus
);
  localparam int ORAMLP1 = ORAML + 1;
  localparam int BlocksOnPath = ORAMLP1 * ORAMZ;
  localparam int ScanTableAWidth = $clog2(BlocksOnPath);
  localparam int BCWidth = $clog2(ORAMZ + 1);
  localparam int LWidth = ORAMLP1 > 1 ? $clog2(ORAMLP1) : 1;
  localparam int InitWidth = $clog2(BlocksOnPath + 1);
  localparam logic [StashEAWidth-1:0] SNULL = '1;
  logic [BCWidth-1:0] count [ORAMLP1];
  logic [InitWidth-1:0] initCount;
  logic [StashEAWidth-1:0] scanTable [BlocksOnPath];
  logic [ORAMLP1-1:0] x, common, full, space;
  logic [LWidth-1:0] level;
  logic [ScanTableAWidth-1:0] slot, ramAddr;
  logic [StashEAWidth-1:0] ramWData;
  logic ramWE, initing, scanValid, accept;
  // Levels shared with the current path are those below the first differing leaf bit.
  assign x = {bus.InLeaf, 1'b0} ^ {bus.CurrentLeaf, 1'b0};
  assign common = (x & (~x + ORAMLP1'(1))) - ORAMLP1'(1);
  always_comb begin
    level = '0;
    full = '0;
    space = '0;
    for (int i = 0; i < ORAMLP1; i++) begin
      full[i] = count[i] == BCWidth'(ORAMZ);
      space[i] = common[i] & ~full[i];
      if (space[i]) level = LWidth'(i);
    end
  end
  assign initing = initCount != InitWidth'(BlocksOnPath);
  assign scanValid = bus.InValid & ~initing;
  assign accept = scanValid & |space;
  assign slot = ScanTableAWidth'(int'(level) * ORAMZ + int'(count[level]));
  assign bus.ResetDone = ~initing;
  assign bus.OutValid = scanValid;
  assign bus.OutAccepted = accept;
  assign bus.OutSAddr = bus.InSAddr;
  // Single table port: init walk beats scan writes, which beat external reads/clears.
  assign ramAddr = initing ? ScanTableAWidth'(initCount) : scanValid ? slot : bus.InSTAddr;
  assign ramWE = initing | accept | (~scanValid & bus.InSTReset);
  assign ramWData = scanValid ? bus.InSAddr : SNULL;
  always_ff @(posedge Clock) begin
    if (ramWE) scanTable[ramAddr] <= ramWData;
    bus.OutSTAddr <= scanTable[ramAddr];
  end
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) begin
      initCount <= '0;
      bus.OutSTValid <= 1'b0;
      for (int i = 0; i < ORAMLP1; i++) count[i] <= '0;
    end else begin
      bus.OutSTValid <= bus.InSTValid;
      if (initing) initCount <= initCount + InitWidth'(1);
      for (int i = 0; i < ORAMLP1; i++)
        if (bus.PerAccessReset) count[i] <= '0;
        else if (accept && level == LWidth'(i)) count[i] <= count[i] + BCWidth'(1);
    end
`ifdef SCAN_TABLE_CHECK_EN
  always_ff @(posedge Clock)
    if (!Reset && bus.InValid && bus.InSTValid) begin
      $display("stash_scan_slotter: scan entry and table read collide on the table port");
      $stop;
    end
`endif
endmodule

// File: tb/tb_stash_scan_slotter.sv
// tb_stash_scan_slotter: vector table, corner sequences and randomized run against a path/bucket model.
module tb_stash_scan_slotter;
  logic Clock = 1'b0;
  logic Reset;
  int checks = 0;
  int errors = 0;
  logic [5:0] mem [16];
  int cnt [4];
  typedef struct {
    logic par;
    logic [2:0] cur;
    logic [2:0] leaf;
    logic [5:0] sAddr;
    logic expAcc;
    int expSlot;
  } vec_t;
  vec_t vecs [13];
  stash_scan_slotter_if #(.ORAML(3), .ORAMZ(4), .StashEAWidth(6)) bus ();
  stash_scan_slotter #(.ORAML(3), .ORAMZ(4), .StashEAWidth(6)) dut (.Clock(Clock), .Reset(Reset), .bus(bus));
  always #5 Clock = ~Clock;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // Level l is shared iff the low l leaf bits agree; deepest shared level with room wins.
  function automatic int placeLevel(input logic [2:0] cur, input logic [2:0] leaf);
    placeLevel = -1;
    for (int l = 0; l < 4; l++)
      if ((int'(cur ^ leaf) % (1 << l)) == 0 && cnt[l] < 4) placeLevel = l;
  endfunction
  task automatic idle();
    bus.InValid = 1'b0;
    bus.InSTValid = 1'b0;
    bus.InSTReset = 1'b0;
    bus.PerAccessReset = 1'b0;
  endtask
  task automatic clearModel();
    for (int i = 0; i < 16; i++) mem[i] = 6'h3F;
    for (int l = 0; l < 4; l++) cnt[l] = 0;
  endtask
  task automatic waitInit();
    int n;
    bus.InValid = 1'b1;
    bus.CurrentLeaf = 3'd0;
    bus.InLeaf = 3'd0;
    for (n = 1; n <= 40; n++) begin
      @(negedge Clock);
      if (bus.ResetDone) break;
      if (n == 5) begin
        chk("initAccepted", bus.OutAccepted, 0);
        chk("initValid", bus.OutValid, 0);
        bus.InValid = 1'b0;
      end
    end
    chk("initCycles", n, 16);
    clearModel();
  endtask
  task automatic readAll();
    for (int i = 0; i <= 16; i++) begin
      @(negedge Clock);
      if (i == 0) chk("rdIdleValid", bus.OutSTValid, 0);
      else begin
        chk("rdValid", bus.OutSTValid, 1);
        chk("rdData", bus.OutSTAddr, mem[i-1]);
      end
      bus.InSTValid = i < 16;
      bus.InSTAddr = 4'(i);
    end
  endtask
  task automatic parCycle();
    @(negedge Clock);
    idle();
    bus.PerAccessReset = 1'b1;
    for (int l = 0; l < 4; l++) cnt[l] = 0;
  endtask
  initial begin
    logic pendRd;
    logic [5:0] pendData;
    logic [3:0] a;
    logic valid, par;
    int lvl;
    Reset = 1'b1;
    idle();
    bus.InSTAddr = 4'd0;
    bus.InSAddr = 6'd0;
    bus.CurrentLeaf = 3'd0;
    bus.InLeaf = 3'd0;
    bus.InValid = 1'b1;
    #1;
    chk("rstResetDone", bus.ResetDone, 0);
    chk("rstOutValid", bus.OutValid, 0);
    chk("rstOutAccepted", bus.OutAccepted, 0);
    chk("rstOutSTValid", bus.OutSTValid, 0);
    repeat (3) @(negedge Clock);
    Reset = 1'b0;
    waitInit();
    readAll();
    vecs = '{
      '{1'b1, 3'd0, 3'd0, 6'd1, 1'b1, 12}, '{1'b0, 3'd0, 3'd0, 6'd2, 1'b1, 13},
      '{1'b0, 3'd0, 3'd0, 6'd3, 1'b1, 14}, '{1'b0, 3'd0, 3'd0, 6'd4, 1'b1, 15},
      '{1'b0, 3'd0, 3'd0, 6'd5, 1'b1, 8},  '{1'b0, 3'd0, 3'd1, 6'd10, 1'b1, 0},
      '{1'b0, 3'd0, 3'd1, 6'd11, 1'b1, 1}, '{1'b0, 3'd0, 3'd1, 6'd12, 1'b1, 2},
      '{1'b0, 3'd0, 3'd1, 6'd13, 1'b1, 3}, '{1'b0, 3'd0, 3'd1, 6'd14, 1'b0, 0},
      '{1'b1, 3'd0, 3'd1, 6'd20, 1'b1, 0}, '{1'b1, 3'd5, 3'd4, 6'd9, 1'b1, 0},
      '{1'b1, 3'd5, 3'd5, 6'd5, 1'b1, 12}
    };
    for (int v = 0; v < 13; v++) begin
      if (vecs[v].par) parCycle();
      @(negedge Clock);
      idle();
      bus.CurrentLeaf = vecs[v].cur;
      bus.InLeaf = vecs[v].leaf;
      bus.InSAddr = vecs[v].sAddr;
      bus.InValid = 1'b1;
      #1;
      chk("vecAccepted", bus.OutAccepted, vecs[v].expAcc);
      chk("vecValid", bus.OutValid, 1);
      chk("vecSAddr", bus.OutSAddr, vecs[v].sAddr);
      if (vecs[v].expAcc) mem[vecs[v].expSlot] = vecs[v].sAddr;
    end
    @(negedge Clock);
    idle();
    readAll();
    @(negedge Clock);
    chk("rdEndValid", bus.OutSTValid, 0);
    bus.InSTAddr = 4'd12;
    bus.InSTValid = 1'b1;
    bus.InSTReset = 1'b1;
    @(negedge Clock);
    chk("clrOldData", bus.OutSTAddr, 5);
    chk("clrOldValid", bus.OutSTValid, 1);
    bus.InSTReset = 1'b0;
    mem[12] = 6'h3F;
    @(negedge Clock);
    chk("clrNewData", bus.OutSTAddr, 6'h3F);
    idle();
    parCycle();
    pendRd = 1'b0;
    pendData = 6'h00;
    for (int it = 0; it < 500; it++) begin
      @(negedge Clock);
      chk("rndSTValid", bus.OutSTValid, pendRd);
      if (pendRd) chk("rndSTData", bus.OutSTAddr, pendData);
      pendRd = 1'b0;
      idle();
      if ($urandom_range(15) == 0) bus.CurrentLeaf = 3'($urandom);
      valid = $urandom_range(3) != 0;
      par = $urandom_range(9) == 0;
      bus.InLeaf = 3'($urandom);
      bus.InSAddr = 6'($urandom);
      bus.InValid = valid;
      bus.PerAccessReset = par;
      if (!valid && $urandom_range(1) == 1) begin
        a = 4'($urandom);
        bus.InSTAddr = a;
        bus.InSTValid = 1'b1;
        bus.InSTReset = 1'($urandom);
        pendRd = 1'b1;
        pendData = mem[a];
        if (bus.InSTReset) mem[a] = 6'h3F;
      end
      lvl = valid ? placeLevel(bus.CurrentLeaf, bus.InLeaf) : -1;
      #1;
      chk("rndResetDone", bus.ResetDone, 1);
      chk("rndValid", bus.OutValid, valid);
      chk("rndAccepted", bus.OutAccepted, lvl >= 0);
      chk("rndSAddr", bus.OutSAddr, bus.InSAddr);
      if (lvl >= 0) mem[lvl * 4 + cnt[lvl]] = bus.InSAddr;
      if (par) for (int l = 0; l < 4; l++) cnt[l] = 0;
      else if (lvl >= 0) cnt[lvl]++;
    end
    @(negedge Clock);
    chk("rndSTValid", bus.OutSTValid, pendRd);
    if (pendRd) chk("rndSTData", bus.OutSTAddr, pendData);
    idle();
    readAll();
    @(negedge Clock);
    idle();
    bus.InSTAddr = 4'd0;
    bus.InSTValid = 1'b1;
    @(posedge Clock);
    #2;
    Reset = 1'b1;
    #1;
    chk("midRstSTValid", bus.OutSTValid, 0);
    chk("midRstDone", bus.ResetDone, 0);
    @(negedge Clock);
    idle();
    Reset = 1'b0;
    waitInit();
    @(negedge Clock);
    bus.CurrentLeaf = 3'd0;
    bus.InLeaf = 3'd0;
    bus.InSAddr = 6'd33;
    bus.InValid = 1'b1;
    #1;
    chk("postRstAccepted", bus.OutAccepted, 1);
    mem[12] = 6'd33;
    @(negedge Clock);
    idle();
    readAll();
    @(negedge Clock);
    idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
